// File: rtl/chess_pkg.sv
// Shared types and constants for the dual-player chess clock.
package chess_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    PLAYER_WHITE = 1'b0,
    PLAYER_BLACK = 1'b1
  } player_e;

  localparam bcd_t MAX_UNITS = 4'd9;
  localparam bcd_t MAX_TENS  = 4'd5;

  localparam int unsigned DEFAULT_START_MINS = 5;
  localparam int unsigned DEFAULT_START_TENS = 0;

endpackage

// File: rtl/bcd_countdown.sv
// One player's M:SS countdown held as three registered BCD digits.
module bcd_countdown
  import chess_pkg::*;
#(
  parameter int unsigned START_MINS = DEFAULT_START_MINS,
  parameter int unsigned START_TENS = DEFAULT_START_TENS
) (
  input  logic clock,
  input  logic globalReset,
  input  logic load,
  input  logic dec,
  output bcd_t mins,
  output bcd_t tensSec,
  output bcd_t unitsSec,
  output logic zero
);

  localparam bcd_t INIT_MINS = bcd_t'(START_MINS);
  localparam bcd_t INIT_TENS = bcd_t'(START_TENS);

  assign zero = (mins == '0) && (tensSec == '0) && (unitsSec == '0);

  // A clock sitting at 0:00 ignores dec, so it can never wrap.
  always_ff @(posedge clock or posedge globalReset) begin
    if (globalReset) begin
      mins     <= INIT_MINS;
      tensSec  <= INIT_TENS;
      unitsSec <= '0;
    end else if (load) begin
      mins     <= INIT_MINS;
      tensSec  <= INIT_TENS;
      unitsSec <= '0;
    end else if (dec && !zero) begin
      if (unitsSec != '0) begin
        unitsSec <= unitsSec - 4'd1;
      end else if (tensSec != '0) begin
        unitsSec <= MAX_UNITS;
        tensSec  <= tensSec - 4'd1;
      end else begin
        unitsSec <= MAX_UNITS;
        tensSec  <= MAX_TENS;
        mins     <= mins - 4'd1;
      end
    end
  end

endmodule

// File: rtl/chess_clock_timer.sv
// Dual countdown chess clock: shared one-second prescaler, turn tracking and sticky flag fall.
module chess_clock_timer
  import chess_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned START_MINS    = DEFAULT_START_MINS,
  parameter int unsigned START_TENS    = DEFAULT_START_TENS
) (
  input  logic       clock,
  input  logic       globalReset,
  input  logic       timerEnable,
  input  logic       blackToMove,
  input  logic       reload,
  output logic [3:0] whiteMins,
  output logic [3:0] whiteTensSec,
  output logic [3:0] whiteUnitsSec,
  output logic [3:0] blackMins,
  output logic [3:0] blackTensSec,
  output logic [3:0] blackUnitsSec,
  output logic       whiteFlag,
  output logic       blackFlag
);

  if (START_MINS < 1 || START_MINS > 9) begin : gBadMins
    $error("chess_clock_timer: START_MINS must be 1..9");
  end
  if (START_TENS > 5) begin : gBadTens
    $error("chess_clock_timer: START_TENS must be 0..5");
  end
  if (TICKS_PER_SEC < 1) begin : gBadTicks
    $error("chess_clock_timer: TICKS_PER_SEC must be at least 1");
  end

  localparam int unsigned PRE_W = $clog2(TICKS_PER_SEC + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  logic [PRE_W-1:0] prescaler;
  player_e          turnReg;
  logic             run;
  logic             turnChange;
  logic             tick;
  logic             decWhite;
  logic             decBlack;
  logic             whiteZero;
  logic             blackZero;
  logic             whiteLastSec;
  logic             blackLastSec;

  assign run        = timerEnable && !whiteFlag && !blackFlag;
  assign turnChange = (turnReg != player_e'(blackToMove));

  always_comb begin
    tick     = 1'b0;
    decWhite = 1'b0;
    decBlack = 1'b0;
    if (run && (prescaler == PRE_LAST) && !turnChange && !reload) begin
      tick = 1'b1;
    end
    if (tick) begin
      decWhite = (turnReg == PLAYER_WHITE);
      decBlack = (turnReg == PLAYER_BLACK);
    end
  end

  always_ff @(posedge clock or posedge globalReset) begin
    if (globalReset) begin
      prescaler <= '0;
      turnReg   <= PLAYER_WHITE;
    end else begin
      turnReg <= player_e'(blackToMove);
      if (reload || turnChange) begin
        prescaler <= '0;
      end else if (run) begin
        prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
      end
    end
  end

  // Flag rises on the same edge that lands the digits on 0:00.
  assign whiteLastSec = (whiteMins == '0) && (whiteTensSec == '0) && (whiteUnitsSec == 4'd1);
  assign blackLastSec = (blackMins == '0) && (blackTensSec == '0) && (blackUnitsSec == 4'd1);

  always_ff @(posedge clock or posedge globalReset) begin
    if (globalReset) begin
      whiteFlag <= 1'b0;
      blackFlag <= 1'b0;
    end else if (reload) begin
      whiteFlag <= 1'b0;
      blackFlag <= 1'b0;
    end else begin
      if (decWhite && whiteLastSec) whiteFlag <= 1'b1;
      if (decBlack && blackLastSec) blackFlag <= 1'b1;
    end
  end

  bcd_countdown #(
    .START_MINS (START_MINS),
    .START_TENS (START_TENS)
  ) uWhite (
    .clock       (clock),
    .globalReset (globalReset),
    .load        (reload),
    .dec         (decWhite),
    .mins        (whiteMins),
    .tensSec     (whiteTensSec),
    .unitsSec    (whiteUnitsSec),
    .zero        (whiteZero)
  );

  bcd_countdown #(
    .START_MINS (START_MINS),
    .START_TENS (START_TENS)
  ) uBlack (
    .clock       (clock),
    .globalReset (globalReset),
    .load        (reload),
    .dec         (decBlack),
    .mins        (blackMins),
    .tensSec     (blackTensSec),
    .unitsSec    (blackUnitsSec),
    .zero        (blackZero)
  );

  logic unusedZero;
  assign unusedZero = whiteZero ^ blackZero;

endmodule
